rxhexword: RTL and testbench

//  Parses a "0x%08x\r\n"-style ASCII hex word out of a received UART byte stream and presents it as a 32-bit value.

---
 rtl/rxhexword.sv | 136 +++++++++++++
 tb/tb_rxhexword.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rxhexword.sv
// Receive-side parser for "0x%08x\r\n"-style ASCII hex words arriving as UART bytes.
// Emits the parsed word with a one-cycle o_stb, or a one-cycle o_err for malformed/stalled frames.
module rxhexword #(
  parameter int unsigned MAX_DIGITS     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 17360
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_stb,
  input  logic [7:0]  i_rx_data,
  output logic        o_stb,
  output logic [31:0] o_data,
  output logic        o_err,
  output logic        o_busy
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    CNT_MAX = 4'(MAX_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    DIGITS
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   acc_q, acc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   data_q, data_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;
  logic          busy_q;

  // Returns {is_hex, nibble} for an ASCII character.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    return r;
  endfunction

  logic [4:0] hex;
  assign hex = hex_decode(i_rx_data);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    timer_d = timer_q;
    data_d  = data_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
    if (i_rx_stb) begin
      timer_d = '0;
      unique case (state_q)
        IDLE: begin
          if (i_rx_data == 8'h30) state_d = ZERO;
        end
        ZERO: begin
          if (i_rx_data == 8'h78 || i_rx_data == 8'h58) begin
            state_d = DIGITS;
            acc_d   = '0;
            cnt_d   = '0;
          end else if (i_rx_data != 8'h30) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        DIGITS: begin
          if (hex[4]) begin
            if (cnt_q < CNT_MAX) begin
              acc_d = {acc_q[27:0], hex[3:0]};
              cnt_d = cnt_q + 4'd1;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (i_rx_data == 8'h0d || i_rx_data == 8'h0a) begin
            state_d = IDLE;
            if (cnt_q != 4'd0) begin
              data_d = acc_q;
              stb_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            // '0' is a hex digit, so a non-digit here can never return to ZERO.
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE || TIMEOUT_CYCLES == 0) begin
      timer_d = '0;
    end else if (timer_q == TLIM) begin
      err_d   = 1'b1;
      state_d = IDLE;
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign o_stb  = stb_q;
  assign o_err  = err_q;
  assign o_data = data_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_rxhexword.sv
// Scoreboard bench for rxhexword: directed frames push expected events, a monitor pops and compares.
module tb_rxhexword;

  localparam int unsigned TMO = 64;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_rx_stb;
  logic [7:0]  i_rx_data;
  logic        o_stb;
  logic [31:0] o_data;
  logic        o_err;
  logic        o_busy;

  rxhexword #(.MAX_DIGITS(8), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_rx_stb(i_rx_stb),
    .i_rx_data(i_rx_data),
    .o_stb(o_stb),
    .o_data(o_data),
    .o_err(o_err),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    if (o_stb === 1'b1 || o_err === 1'b1) begin
      total++;
      if (o_stb === 1'b1 && o_err === 1'b1) begin
        bad++;
        $display("FAIL stb_err_same_cycle: o_stb=%b o_err=%b required not both", o_stb, o_err);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: o_stb=%b o_err=%b o_data=%h required no event", o_stb, o_err, o_data);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          if (o_err !== 1'b1) begin
            bad++;
            $display("FAIL event_kind: got stb data=%h required err", o_data);
          end
        end else if (o_stb !== 1'b1 || o_data !== e.data) begin
          bad++;
          $display("FAIL word: o_stb=%b o_data=%h required stb data=%h", o_stb, o_data, e.data);
        end
      end
    end
  end

  task automatic push_stb(input logic [31:0] d);
    ev_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    exp_q.push_back(e);
  endtask

  // Bytes go out back-to-back on consecutive cycles.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge i_clk);
      i_rx_stb  = 1'b1;
      i_rx_data = s[i];
    end
    @(negedge i_clk);
    i_rx_stb  = 1'b0;
    i_rx_data = 8'hxx;
  endtask

  task automatic drain(input string name, input int cycles);
    repeat (cycles) @(negedge i_clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: pending_events=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  initial begin
    i_reset   = 1'b1;
    i_rx_stb  = 1'b0;
    i_rx_data = 8'h00;
    repeat (3) @(negedge i_clk);
    check("reset_stb", {31'b0, o_stb}, 32'd0);
    check("reset_err", {31'b0, o_err}, 32'd0);
    check("reset_busy", {31'b0, o_busy}, 32'd0);
    check("reset_data", o_data, 32'h0);
    i_reset = 1'b0;

    push_stb(32'h1234abcd);
    send_str("0x1234abcd\015");
    check("busy_after_cr", {31'b0, o_busy}, 32'd0);
    send_str("\012");
    drain("full_word", 5);
    check("full_word_data", o_data, 32'h1234abcd);

    push_stb(32'h000000ff);
    send_str("0XfF\012");
    drain("short_word", 5);
    send_str("zzz");
    drain("ignored_junk", 5);
    check("junk_keeps_data", o_data, 32'h000000ff);

    push_err();
    send_str("0x123456789\015");
    drain("overflow", 5);
    check("overflow_keeps_data", o_data, 32'h000000ff);

    push_err();
    send_str("0x\015");
    push_err();
    send_str("0q");
    drain("empty_and_bad", 5);
    check("errors_keep_data", o_data, 32'h000000ff);
    push_stb(32'h00000007);
    send_str("0x7\015");
    drain("after_errors", 5);

    push_stb(32'h0000001a);
    send_str("000x1A\012");
    drain("leading_zeros", 5);

    push_err();
    send_str("0x12");
    check("busy_mid_frame", {31'b0, o_busy}, 32'd1);
    drain("timeout", TMO + 10);
    check("busy_after_timeout", {31'b0, o_busy}, 32'd0);
    push_stb(32'h00000003);
    send_str("0x3\015");
    drain("after_timeout", 5);

    // Reset mid-frame, with a '0' strobe in the reset cycle that must be discarded.
    send_str("0x5a");
    @(negedge i_clk);
    i_reset   = 1'b1;
    i_rx_stb  = 1'b1;
    i_rx_data = 8'h30;
    @(negedge i_clk);
    i_reset   = 1'b0;
    i_rx_stb  = 1'b0;
    check("reset_wins_busy", {31'b0, o_busy}, 32'd0);
    check("reset_clears_data", o_data, 32'h0);
    send_str("6\015");
    drain("after_reset", 5);
    check("after_reset_data", o_data, 32'h0);
    check("after_reset_busy", {31'b0, o_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
